// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e  : transaction FSM states
//   owner_e  : which requester owns the outstanding transaction
//   DEF_*    : default timeout and starvation-guard limits
//   cnt_width: counter width able to hold 0..max_val
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam int unsigned DEF_TIMEOUT  = 1023;
  localparam int unsigned DEF_MAX_WAIT = 8;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the two requesters (IFU, LSU) and memory.
//   slave  : the arbiter's view (requests and memory responses come in)
//   master : the surrounding system (requesters and memory)
interface mem_arbiter_if;

  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/mem_arbiter_timer.sv
// Transaction timeout counter: clearable, saturating at TIMEOUT.
//   clock, reset : clock, asynchronous active-low reset
//   clear        : restart from zero
//   enable       : count this cycle
//   hit          : count has reached TIMEOUT while enabled
module mem_arbiter_timer
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int unsigned   W     = cnt_width(TIMEOUT);
  localparam logic [W-1:0]  LIMIT = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  assign hit = enable && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter between IFU and LSU, one transaction in
// flight. LSU has priority; IFU wins once it has waited MAX_WAIT cycles.
// A transaction stuck in REQ/WAIT for TIMEOUT cycles completes with an error.
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : IFU/LSU request+response and memory request+response signals
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned   WW       = cnt_width(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

  state_e        state;
  state_e        state_next;
  owner_e        owner;
  logic [31:0]   addr_q;
  logic          wen_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wmask_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          stale;
  logic [WW-1:0] wait_cnt;

  logic ifu_grant;
  logic lsu_grant;
  logic accept;
  logic busy;
  logic hit;
  logic resp_ok;
  logic abort;

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    ifu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (reset && (state == IDLE)) begin
      if (bus.ifu_req_valid && ((wait_cnt >= WAIT_SAT) || !bus.lsu_req_valid)) begin
        ifu_grant = 1'b1;
      end else if (bus.lsu_req_valid) begin
        lsu_grant = 1'b1;
      end
    end
  end

  assign accept  = ifu_grant | lsu_grant;
  assign busy    = (state == REQ) || (state == WAIT);
  assign resp_ok = (state == WAIT) && bus.mem_resp_valid && !stale;
  // A genuine response in the timeout cycle wins over the abort.
  assign abort   = hit && !resp_ok;

  mem_arbiter_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (busy),
    .hit    (hit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next         = state;
    bus.ifu_req_ready  = ifu_grant;
    bus.lsu_req_ready  = lsu_grant;
    bus.mem_req_valid  = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wen        = 1'b0;
    bus.mem_wdata      = '0;
    bus.mem_wmask      = '0;
    bus.ifu_resp_valid = 1'b0;
    bus.ifu_rdata      = '0;
    bus.ifu_resp_err   = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    bus.lsu_rdata      = '0;
    bus.lsu_resp_err   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = REQ;
      end
      REQ: begin
        // Request is withdrawn in the timeout cycle so no handshake can occur.
        if (!hit) begin
          bus.mem_req_valid = 1'b1;
          bus.mem_addr      = addr_q;
          bus.mem_wen       = wen_q;
          bus.mem_wdata     = wdata_q;
          bus.mem_wmask     = wmask_q;
        end
        if (hit) begin
          state_next = RESP;
        end else if (bus.mem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (resp_ok || hit) state_next = RESP;
      end
      RESP: begin
        if (owner == OWN_IFU) begin
          bus.ifu_resp_valid = 1'b1;
          bus.ifu_rdata      = rdata_q;
          bus.ifu_resp_err   = err_q;
        end else begin
          bus.lsu_resp_valid = 1'b1;
          bus.lsu_rdata      = rdata_q;
          bus.lsu_resp_err   = err_q;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner    <= OWN_IFU;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      stale    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        owner   <= ifu_grant ? OWN_IFU : OWN_LSU;
        addr_q  <= ifu_grant ? bus.ifu_addr : bus.lsu_addr;
        wen_q   <= !ifu_grant && bus.lsu_wen;
        wdata_q <= ifu_grant ? '0 : bus.lsu_wdata;
        wmask_q <= ifu_grant ? '0 : bus.lsu_wmask;
      end

      // Writes return no data to the LSU regardless of what memory drives.
      if (resp_ok) begin
        rdata_q <= wen_q ? '0 : bus.mem_rdata;
        err_q   <= bus.mem_resp_err;
      end else if (abort) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end

      // An abandoned WAIT leaves one response in flight; swallow it later.
      if (abort && (state == WAIT)) begin
        stale <= 1'b1;
      end else if (bus.mem_resp_valid && stale) begin
        stale <= 1'b0;
      end

      if (ifu_grant) begin
        wait_cnt <= '0;
      end else if (bus.ifu_req_valid && (wait_cnt < WAIT_SAT)) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clock;
  logic reset;

  mem_arbiter_if bus();

  mem_arbiter #(
    .TIMEOUT  (16),
    .MAX_WAIT (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model controls (written by the main sequence only).
  logic [31:0] mem_data = '0;
  logic        mem_err  = 1'b0;
  logic        mem_mute = 1'b0;
  int          late_req = 0;
  // Memory model state (written by the model only).
  int          late_done = 0;
  bit          pend;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Zero-wait memory: answers in the cycle after a request handshake.
  // A late_req bump injects one unsolicited 0xbad response.
  initial begin
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    bus.mem_resp_err   = 1'b0;
    forever begin
      @(negedge clock);
      pend = bus.mem_req_valid && bus.mem_req_ready;
      @(posedge clock); #1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = '0;
      bus.mem_resp_err   = 1'b0;
      if (pend && !mem_mute) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = mem_data;
        bus.mem_resp_err   = mem_err;
      end else if (late_req != late_done) begin
        late_done++;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0bad;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Full transaction through a zero-wait memory; entered and left at posedge+1.
  task automatic txn_fixed(input string tag, input bit lsu, input logic [31:0] addr,
                           input bit wen, input logic [31:0] wdata, input logic [3:0] wmask,
                           input logic [31:0] rsp_data, input bit rsp_err,
                           input logic [31:0] exp_rdata);
    mem_data = rsp_data;
    mem_err  = rsp_err;
    if (lsu) begin
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = addr;
      bus.lsu_wen       = wen;
      bus.lsu_wdata     = wdata;
      bus.lsu_wmask     = wmask;
    end else begin
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = addr;
    end
    @(negedge clock);
    check({tag, ".ready"}, lsu ? bus.lsu_req_ready : bus.ifu_req_ready, 1);
    step();
    bus.lsu_req_valid = 1'b0;
    bus.ifu_req_valid = 1'b0;
    @(negedge clock);
    check({tag, ".mem_valid"}, bus.mem_req_valid, 1);
    check({tag, ".mem_addr"},  bus.mem_addr, addr);
    check({tag, ".mem_wen"},   bus.mem_wen, wen);
    check({tag, ".mem_wdata"}, bus.mem_wdata, wdata);
    check({tag, ".mem_wmask"}, bus.mem_wmask, wmask);
    step();
    @(negedge clock);
    check({tag, ".no_early_resp"}, lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid, 0);
    step();
    @(negedge clock);
    check({tag, ".resp_valid"}, lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid, 1);
    check({tag, ".rdata"},      lsu ? bus.lsu_rdata : bus.ifu_rdata, exp_rdata);
    check({tag, ".err"},        lsu ? bus.lsu_resp_err : bus.ifu_resp_err, rsp_err);
    check({tag, ".other_quiet"}, lsu ? bus.ifu_resp_valid : bus.lsu_resp_valid, 0);
    step();
    @(negedge clock);
    check({tag, ".pulse_end"}, lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid, 0);
    check({tag, ".idle"}, dut.state, IDLE);
    step();
  endtask

  // LSU read against a silent memory; returns cycles from handshake to response.
  task automatic lsu_timeout(input string tag, input logic [31:0] addr, input bit in_req);
    int n;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = addr;
    bus.lsu_wen       = 1'b0;
    @(negedge clock);
    check({tag, ".ready"}, bus.lsu_req_ready, 1);
    step();
    bus.lsu_req_valid = 1'b0;
    n = 1;
    @(negedge clock);
    while (!bus.lsu_resp_valid && n < 40) begin
      if (in_req && n == 16) check({tag, ".req_held"}, bus.mem_req_valid, 1);
      step();
      n++;
      @(negedge clock);
      if (in_req && n == 17) check({tag, ".req_dropped"}, bus.mem_req_valid, 0);
    end
    check({tag, ".latency"}, n, 18);
    check({tag, ".resp_valid"}, bus.lsu_resp_valid, 1);
    check({tag, ".err"}, bus.lsu_resp_err, 1);
    check({tag, ".rdata"}, bus.lsu_rdata, 0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    bus.mem_req_ready = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst.state",    dut.state, IDLE);
    check("rst.wait_cnt", dut.wait_cnt, 0);
    check("rst.stale",    dut.stale, 0);
    check("rst.mem_valid", bus.mem_req_valid, 0);
    check("rst.ifu_resp", bus.ifu_resp_valid, 0);
    check("rst.lsu_resp", bus.lsu_resp_valid, 0);
    @(posedge clock); step();
    reset = 1'b1;

    // 1: IFU-only read
    txn_fixed("t1", 1'b0, 32'h8000_0000, 1'b0, '0, '0, 32'hdead_beef, 1'b0, 32'hdead_beef);

    // 2: simultaneous LSU write and IFU read; LSU first, then IFU
    mem_data = 32'ha5a5_a5a5;
    mem_err  = 1'b0;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_1000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 32'h1234_5678;
    bus.lsu_wmask     = 4'hf;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0100;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      case (c)
        0: begin
          check("t2.lsu_first", bus.lsu_req_ready, 1);
          check("t2.ifu_blocked", bus.ifu_req_ready, 0);
        end
        1: begin
          check("t2.busy_no_ready", bus.ifu_req_ready, 0);
          check("t2.mem_addr",  bus.mem_addr, 32'h8000_1000);
          check("t2.mem_wen",   bus.mem_wen, 1);
          check("t2.mem_wdata", bus.mem_wdata, 32'h1234_5678);
          check("t2.mem_wmask", bus.mem_wmask, 4'hf);
        end
        3: begin
          check("t2.lsu_resp",  bus.lsu_resp_valid, 1);
          check("t2.lsu_wr_rdata", bus.lsu_rdata, 0);
          check("t2.ifu_quiet", bus.ifu_resp_valid, 0);
        end
        4: check("t2.ifu_next", bus.ifu_req_ready, 1);
        5: begin
          check("t2.ifu_mem_addr", bus.mem_addr, 32'h8000_0100);
          check("t2.ifu_mem_wen",  bus.mem_wen, 0);
        end
        7: begin
          check("t2.ifu_resp",  bus.ifu_resp_valid, 1);
          check("t2.ifu_rdata", bus.ifu_rdata, 32'h0000_0297);
        end
        default: ;
      endcase
      step();
      if (c == 0) bus.lsu_req_valid = 1'b0;
      if (c == 4) begin
        bus.ifu_req_valid = 1'b0;
        mem_data = 32'h0000_0297;
      end
    end

    // 3: starvation guard with LSU continuously valid
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_2000;
    bus.lsu_wen       = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0200;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clock);
      case (c)
        0, 4, 12: begin
          check($sformatf("t3.lsu_grant_c%0d", c), bus.lsu_req_ready, 1);
          check($sformatf("t3.ifu_wait_c%0d", c), bus.ifu_req_ready, 0);
        end
        1, 5: begin
          check($sformatf("t3.no_ready_ifu_c%0d", c), bus.ifu_req_ready, 0);
          check($sformatf("t3.no_ready_lsu_c%0d", c), bus.lsu_req_ready, 0);
        end
        8: begin
          check("t3.wait_cnt_sat", dut.wait_cnt, 8);
          check("t3.ifu_grant", bus.ifu_req_ready, 1);
          check("t3.lsu_held", bus.lsu_req_ready, 0);
        end
        9:  check("t3.wait_cnt_clr", dut.wait_cnt, 0);
        11: check("t3.ifu_resp", bus.ifu_resp_valid, 1);
        default: ;
      endcase
      step();
      if (c == 8) bus.ifu_req_valid = 1'b0;
      if (c == 12) bus.lsu_req_valid = 1'b0;
    end

    // 4: timeout in WAIT, late response discarded, next IFU read clean
    mem_mute = 1'b1;
    lsu_timeout("t4", 32'h8000_3000, 1'b0);
    @(negedge clock);
    check("t4.stale_set", dut.stale, 1);
    late_req++;
    mem_mute = 1'b0;
    step();
    @(negedge clock);
    check("t4.late_ifu_quiet", bus.ifu_resp_valid, 0);
    check("t4.late_lsu_quiet", bus.lsu_resp_valid, 0);
    step();
    @(negedge clock);
    check("t4.stale_clr", dut.stale, 0);
    step();
    txn_fixed("t4r", 1'b0, 32'h8000_0040, 1'b0, '0, '0, 32'h0000_0013, 1'b0, 32'h0000_0013);

    // 4b: timeout while the request is still unaccepted
    bus.mem_req_ready = 1'b0;
    lsu_timeout("t4b", 32'h8000_3100, 1'b1);
    @(negedge clock);
    check("t4b.no_stale", dut.stale, 0);
    step();
    bus.mem_req_ready = 1'b1;

    // 5: memory error on LSU read
    txn_fixed("t5", 1'b1, 32'h8000_4000, 1'b0, '0, '0, 32'h55aa_55aa, 1'b1, 32'h55aa_55aa);

    // 6: asynchronous reset in WAIT
    mem_mute = 1'b1;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_5000;
    bus.lsu_wen       = 1'b0;
    step();
    bus.lsu_req_valid = 1'b0;
    step();
    @(negedge clock);
    check("t6.in_wait", dut.state, WAIT);
    @(posedge clock); #2;
    bus.ifu_req_valid = 1'b1;
    reset = 1'b0;
    #1;
    check("t6.state",     dut.state, IDLE);
    check("t6.ifu_ready", bus.ifu_req_ready, 0);
    check("t6.lsu_ready", bus.lsu_req_ready, 0);
    check("t6.mem_valid", bus.mem_req_valid, 0);
    check("t6.mem_addr",  bus.mem_addr, 0);
    check("t6.lsu_resp",  bus.lsu_resp_valid, 0);
    check("t6.ifu_resp",  bus.ifu_resp_valid, 0);
    bus.ifu_req_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    mem_mute = 1'b0;
    txn_fixed("t6r", 1'b0, 32'h8000_0000, 1'b0, '0, '0, 32'hdead_beef, 1'b0, 32'hdead_beef);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single data-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) in the multi-cycle core. It handles one outstanding transaction at a time. LSU has fixed priority over IFU, and a starvation guard forces an IFU grant after a bounded wait. A response timeout turns a hung memory into an error response instead of a core hang.

Parameters:
TIMEOUT, 1023, cycles in REQ or WAIT before the transaction is aborted with an error.
MAX_WAIT, 8, IFU wait cycles (valid but not granted) before IFU wins arbitration.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted
ifu_addr  in  32  IFU read address
ifu_resp_valid  out  1  one-cycle IFU response pulse
ifu_rdata  out  32  IFU read data
ifu_resp_err  out  1  IFU response error
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted
lsu_addr  in  32  LSU address
lsu_wen  in  1  1 = write, 0 = read
lsu_wdata  in  32  LSU write data
lsu_wmask  in  4  byte write mask
lsu_resp_valid  out  1  one-cycle LSU response pulse
lsu_rdata  out  32  LSU read data (0 for writes)
lsu_resp_err  out  1  LSU response error
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_addr  out  32  memory address
mem_wen  out  1  memory write enable
mem_wdata  out  32  memory write data
mem_wmask  out  4  memory byte mask
mem_resp_valid  in  1  memory response
mem_rdata  in  32  memory read data
mem_resp_err  in  1  memory error

Behaviour:
- Reset (reset low, asynchronous) sets state = IDLE and clears owner, timer, wait_cnt and stale. All outputs read 0.
- States and transitions:
  - IDLE -> REQ on a request handshake.
  - REQ -> WAIT on mem_req_ready.
  - WAIT -> RESP on a non-stale mem_resp_valid.
  - RESP -> IDLE unconditionally.
  - REQ or WAIT -> RESP when the timer reaches TIMEOUT.
- Arbitration in IDLE only, combinational ready:
  - IFU wins if ifu_req_valid and (wait_cnt >= MAX_WAIT or !lsu_req_valid).
  - Otherwise LSU wins if lsu_req_valid.
  - Only the winner's ready is 1. Both readys are 0 outside IDLE.
- On a handshake the arbiter latches the owner and request fields (IFU: wen=0, wdata=0, wmask=0).
- Requesters hold their request fields stable while valid and not ready.
- REQ: mem_req_valid=1 with the latched fields, held until mem_req_ready.
- WAIT: a non-stale mem_resp_valid captures mem_rdata and mem_resp_err into response registers.
- RESP: the owner's resp_valid=1 for exactly one cycle, with the registered rdata and err. The other owner's outputs stay 0.
- Requesters always accept responses; there is no resp_ready.
- Minimum latency with zero-wait memory: handshake at cycle 0, mem handshake at cycle 1, mem resp at cycle 2, resp_valid at cycle 3, IDLE at cycle 4.
- Timer:
  - Cleared on entering REQ.
  - Increments each cycle in REQ or WAIT.
  - At TIMEOUT: go to RESP with err=1 and rdata=0.
  - A timeout in REQ drops mem_req_valid without handshake.
  - A timeout in WAIT sets stale=1.
- stale: the next mem_resp_valid, in any state, is discarded and clears stale. If a response arrives in WAIT while stale=1, the arbiter discards it, clears stale and stays in WAIT.
- Any mem_resp_valid outside WAIT with stale=0 is ignored.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) in each cycle where ifu_req_valid=1 and IFU has no handshake.
  - Cleared on an IFU handshake.
  - Held when ifu_req_valid=0.

Decomposition:
- Shared package holds:
  - the state enum IDLE/REQ/WAIT/RESP;
  - the owner encoding OWN_IFU=0, OWN_LSU=1;
  - the default TIMEOUT and MAX_WAIT constants.
- One natural sub-module, mem_arbiter_timer: a clearable saturating counter with TIMEOUT compare and hit output.
- Arbitration and the FSM stay in the top.

Test Plan:
1. IFU-only read: ifu_addr=0x80000000, memory ready immediately, returns 0xdeadbeef one cycle after accept. Required: ifu_resp_valid pulses at cycle 3 with rdata=0xdeadbeef and err=0; lsu_resp_valid stays 0.
2. Simultaneous requests: LSU write (0x80001000, 0x12345678, wmask=0xF) and IFU read. Required: LSU is granted first and memory sees wen=1 with matching fields; IFU is granted at the next IDLE.
3. Starvation: LSU valid continuously and IFU valid with MAX_WAIT=8. Required: IFU is granted at the first IDLE after wait_cnt reaches 8 despite lsu_req_valid=1; wait_cnt reads 0 afterwards.
4. Timeout: mem_req_ready=1 and no response, TIMEOUT=16. Required: lsu_resp_valid with err=1 and rdata=0 after 16 WAIT cycles. A late response (0xbad) is then discarded, and the next IFU read returns its own 0x00000013.
5. Error propagation: mem_resp_err=1 on an LSU read. Required: lsu_resp_err=1 with the returned rdata.
6. Reset mid-WAIT: drive reset low asynchronously. Required: all outputs are 0 immediately and the state is IDLE. After release, scenario 1 passes unchanged.
